// File: rtl/drap_regfile_bist_if.sv
// Register-file port bundle between the BIST controller (master) and DRAP_REGFILE (slave).
interface drap_regfile_bist_if;
    logic        wr_en;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [4:0]  r_addr1;
    logic [4:0]  r_addr2;
    logic [31:0] r_data1;
    logic [31:0] r_data2;

    modport master (
        output wr_en, w_addr, w_data, r_addr1, r_addr2,
        input  r_data1, r_data2
    );

    modport slave (
        input  wr_en, w_addr, w_data, r_addr1, r_addr2,
        output r_data1, r_data2
    );
endinterface

// File: rtl/drap_regfile_bist.sv
// BIST controller for the 32x32 DRAP_REGFILE: two write/read-back passes with
// complementary patterns, saturating mismatch count and first-failure capture.
module drap_regfile_bist #(
    parameter int RD_LAT  = 0,    // 0: combinational read, 1: registered read
    parameter bit SKIP_R0 = 1'b1  // 1: r0 is hardwired zero
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [5:0]           err_count,
    output logic [4:0]           fail_addr,
    output logic [31:0]          fail_data,
    drap_regfile_bist_if.master  rf
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RWAIT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        p_q, p_d;           // current pass
    logic [4:0]  cnt_q, cnt_d;       // write address in WRITE, pair index k in READ/RWAIT
    logic        wr_en_q, wr_en_d;
    logic [4:0]  w_addr_q, w_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic [4:0]  r_addr1_q, r_addr1_d;
    logic [4:0]  r_addr2_q, r_addr2_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [5:0]  err_count_q, err_count_d;
    logic [4:0]  fail_addr_q, fail_addr_d;
    logic [31:0] fail_data_q, fail_data_d;

    logic        cmp_en;
    logic        step;
    logic        mis1, mis2;
    logic [3:0]  k;
    logic [4:0]  addr1, addr2;
    logic [6:0]  err_sum;

    function automatic logic [31:0] pat(input logic p, input logic [4:0] a);
        return (p ? 32'hAAAA_AAAA : 32'h5555_5555) ^ {27'd0, a};
    endfunction

    function automatic logic [31:0] exp_val(input logic p, input logic [4:0] a);
        if (SKIP_R0 && a == 5'd0)
            return 32'd0;
        return pat(p, a);
    endfunction

    assign k     = cnt_q[3:0];
    assign addr1 = {k, 1'b0};
    assign addr2 = {k, 1'b1};

    // Next-state, compare and registered-output computation.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        cnt_d       = cnt_q;
        wr_en_d     = 1'b0;
        w_addr_d    = 5'd0;
        w_data_d    = 32'd0;
        r_addr1_d   = 5'd0;
        r_addr2_d   = 5'd0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        step        = 1'b0;

        // Compare happens in READ for combinational reads, in RWAIT for registered reads.
        cmp_en  = ((state_q == S_READ) && (RD_LAT == 0)) || (state_q == S_RWAIT);
        mis1    = cmp_en && (rf.r_data1 != exp_val(p_q, addr1));
        mis2    = cmp_en && (rf.r_data2 != exp_val(p_q, addr2));
        err_sum = {1'b0, err_count_q} + 7'(mis1) + 7'(mis2);

        if (cmp_en) begin
            err_count_d = (err_sum > 7'd63) ? 6'd63 : err_sum[5:0];
            // First failure only; port 1 (lower address) wins a tie.
            if (err_count_q == 6'd0 && (mis1 || mis2)) begin
                fail_addr_d = mis1 ? addr1 : addr2;
                fail_data_d = mis1 ? rf.r_data1 : rf.r_data2;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WRITE;
                    p_d         = 1'b0;
                    cnt_d       = 5'd0;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    err_count_d = 6'd0;
                    fail_addr_d = 5'd0;
                    fail_data_d = 32'd0;
                    wr_en_d     = 1'b1;
                    w_addr_d    = 5'd0;
                    w_data_d    = pat(1'b0, 5'd0);
                end
            end
            S_WRITE: begin
                if (cnt_q == 5'd31) begin
                    state_d   = S_READ;
                    cnt_d     = 5'd0;
                    r_addr1_d = 5'd0;
                    r_addr2_d = 5'd1;
                end else begin
                    cnt_d    = 5'(cnt_q + 5'd1);
                    wr_en_d  = 1'b1;
                    w_addr_d = 5'(cnt_q + 5'd1);
                    w_data_d = pat(p_q, 5'(cnt_q + 5'd1));
                end
            end
            S_READ: begin
                if (RD_LAT != 0) begin
                    // Hold addresses while the registered read data arrives.
                    state_d   = S_RWAIT;
                    r_addr1_d = r_addr1_q;
                    r_addr2_d = r_addr2_q;
                end else begin
                    step = 1'b1;
                end
            end
            S_RWAIT: step = 1'b1;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Advance to the next read pair, the second pass, or completion.
        if (step) begin
            if (k == 4'd15) begin
                if (!p_q) begin
                    state_d  = S_WRITE;
                    p_d      = 1'b1;
                    cnt_d    = 5'd0;
                    wr_en_d  = 1'b1;
                    w_addr_d = 5'd0;
                    w_data_d = pat(1'b1, 5'd0);
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    pass_d  = (err_count_d == 6'd0);
                end
            end else begin
                state_d   = S_READ;
                cnt_d     = 5'(cnt_q + 5'd1);
                r_addr1_d = {4'(k + 4'd1), 1'b0};
                r_addr2_d = {4'(k + 4'd1), 1'b1};
            end
        end
    end

    // State and output registers; synchronous reset aborts any test in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            p_q         <= 1'b0;
            cnt_q       <= 5'd0;
            wr_en_q     <= 1'b0;
            w_addr_q    <= 5'd0;
            w_data_q    <= 32'd0;
            r_addr1_q   <= 5'd0;
            r_addr2_q   <= 5'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 6'd0;
            fail_addr_q <= 5'd0;
            fail_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            r_addr1_q   <= r_addr1_d;
            r_addr2_q   <= r_addr2_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign fail_addr  = fail_addr_q;
    assign fail_data  = fail_data_q;
    assign rf.wr_en   = wr_en_q;
    assign rf.w_addr  = w_addr_q;
    assign rf.w_data  = w_data_q;
    assign rf.r_addr1 = r_addr1_q;
    assign rf.r_addr2 = r_addr2_q;

endmodule

// File: tb/tb_drap_regfile_bist.sv
// Bench for drap_regfile_bist: three instances (ideal/RD_LAT0, SKIP_R0=0, RD_LAT1),
// each with a register-file model that can inject faults, checked every cycle
// against a timeline model plus literal expectations.
module tb_drap_regfile_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst;
    logic [2:0]       start;
    logic [2:0]       busy_o, done_o, pass_o, wr_o;
    logic [2:0][5:0]  err_o;
    logic [2:0][4:0]  fa_o, wa_o, ra1_o, ra2_o;
    logic [2:0][31:0] fd_o, wd_o;

    bit stuck9 = 1'b0;  // instance 0: bit 3 of r9 stuck at 0
    bit drop45 = 1'b0;  // instance 0: r4/r5 store 0 during pass 0

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int RL = (g == 2) ? 1 : 0;
        localparam bit SK = (g != 1);
        drap_regfile_bist_if rf_if ();
        logic [31:0] mem [32];
        int          wcnt0;
        logic [31:0] rq1, rq2;
        logic [31:0] v;

        drap_regfile_bist #(.RD_LAT(RL), .SKIP_R0(SK)) u_dut (
            .clk(clk), .rst(rst[g]), .start(start[g]),
            .busy(busy_o[g]), .done(done_o[g]), .pass(pass_o[g]),
            .err_count(err_o[g]), .fail_addr(fa_o[g]), .fail_data(fd_o[g]),
            .rf(rf_if)
        );

        initial begin
            for (int i = 0; i < 32; i++) mem[i] = 32'd0;
            wcnt0 = 0;
        end

        always @(posedge clk) begin
            if (rf_if.wr_en) begin
                v = rf_if.w_data;
                if (g == 0 && stuck9 && rf_if.w_addr == 5'd9) v[3] = 1'b0;
                if (g == 0 && drop45 && wcnt0 == 1 && (rf_if.w_addr == 5'd4 || rf_if.w_addr == 5'd5)) v = 32'd0;
                mem[rf_if.w_addr] <= v;
            end
            if (start[g] && !busy_o[g]) wcnt0 <= 0;
            else if (rf_if.wr_en && rf_if.w_addr == 5'd0) wcnt0 <= wcnt0 + 1;
            rq1 <= (rf_if.r_addr1 == 5'd0) ? 32'd0 : mem[rf_if.r_addr1];
            rq2 <= (rf_if.r_addr2 == 5'd0) ? 32'd0 : mem[rf_if.r_addr2];
        end

        assign rf_if.r_data1 = (RL == 1) ? rq1 : ((rf_if.r_addr1 == 5'd0) ? 32'd0 : mem[rf_if.r_addr1]);
        assign rf_if.r_data2 = (RL == 1) ? rq2 : ((rf_if.r_addr2 == 5'd0) ? 32'd0 : mem[rf_if.r_addr2]);
        assign wr_o[g]  = rf_if.wr_en;
        assign wa_o[g]  = rf_if.w_addr;
        assign wd_o[g]  = rf_if.w_data;
        assign ra1_o[g] = rf_if.r_addr1;
        assign ra2_o[g] = rf_if.r_addr2;
    end

    // ---------------- behavioural model ----------------
    function automatic logic [31:0] pat(input int p, input int a);
        return (p != 0 ? 32'hAAAA_AAAA : 32'h5555_5555) ^ 32'(a);
    endfunction

    // Value the faulty/ideal register file returns for register a in pass p.
    function automatic logic [31:0] mrd(input int i, input int p, input int a);
        logic [31:0] r;
        r = pat(p, a);
        if (i == 0 && stuck9 && a == 9) r[3] = 1'b0;
        if (i == 0 && drop45 && p == 0 && (a == 4 || a == 5)) r = 32'd0;
        if (a == 0) r = 32'd0;
        return r;
    endfunction

    function automatic logic [31:0] mexp(input int i, input int p, input int a);
        if (i != 1 && a == 0) return 32'd0;
        return pat(p, a);
    endfunction

    function automatic int rcyc(input int i); return (i == 2) ? 2 : 1; endfunction
    function automatic int plen(input int i); return 32 + 16 * rcyc(i); endfunction
    function automatic int tot(input int i);  return 2 * plen(i) + 1; endfunction

    // Error state visible in test cycle t: all compares whose last cycle is before t.
    task automatic model_err(input int i, input int t, output int e, output int fa, output logic [31:0] fd);
        int ec;
        e = 0; fa = 0; fd = 32'd0;
        for (int p = 0; p < 2; p++)
            for (int kk = 0; kk < 16; kk++) begin
                ec = 1 + p * plen(i) + 32 + kk * rcyc(i) + rcyc(i) - 1;
                if (ec < t)
                    for (int j = 0; j < 2; j++)
                        if (mrd(i, p, 2 * kk + j) != mexp(i, p, 2 * kk + j)) begin
                            if (e == 0) begin fa = 2 * kk + j; fd = mrd(i, p, 2 * kk + j); end
                            if (e < 63) e++;
                        end
            end
    endtask

    bit          m_run  [3];
    int          m_t    [3];
    int          m_err  [3];
    int          m_fa   [3];
    logic [31:0] m_fd   [3];
    bit          m_pass [3];

    initial for (int i = 0; i < 3; i++) begin
        m_run[i] = 0; m_t[i] = 0; m_err[i] = 0; m_fa[i] = 0; m_fd[i] = 0; m_pass[i] = 0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst[i]) begin
                m_run[i] = 0; m_t[i] = 0; m_err[i] = 0; m_fa[i] = 0; m_fd[i] = 32'd0; m_pass[i] = 0;
            end else if (m_run[i]) begin
                if (m_t[i] == tot(i)) begin
                    m_run[i] = 0;
                    model_err(i, tot(i) + 1, m_err[i], m_fa[i], m_fd[i]);
                    m_pass[i] = (m_err[i] == 0);
                end else begin
                    m_t[i]++;
                end
            end else if (start[i]) begin
                m_run[i] = 1; m_t[i] = 1;
                m_err[i] = 0; m_fa[i] = 0; m_fd[i] = 32'd0; m_pass[i] = 0;
            end
        end
    end

    // Compare every output of every instance each cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit ebusy, edone, ewr, epass;
            int ewa, era1, era2, eerr, efa, t, u, p, vv;
            logic [31:0] ewd, efd;
            ebusy = 0; edone = 0; ewr = 0; ewa = 0; ewd = 0; era1 = 0; era2 = 0;
            eerr = m_err[i]; efa = m_fa[i]; efd = m_fd[i]; epass = m_pass[i];
            if (m_run[i]) begin
                t = m_t[i];
                ebusy = (t < tot(i));
                edone = (t == tot(i));
                if (t < tot(i)) begin
                    u = t - 1; p = u / plen(i); vv = u % plen(i);
                    if (vv < 32) begin ewr = 1; ewa = vv; ewd = pat(p, vv); end
                    else begin era1 = 2 * ((vv - 32) / rcyc(i)); era2 = era1 + 1; end
                end
                model_err(i, t, eerr, efa, efd);
                epass = edone && (eerr == 0);
            end
            chk($sformatf("i%0d busy", i),      32'(busy_o[i]), 32'(ebusy));
            chk($sformatf("i%0d done", i),      32'(done_o[i]), 32'(edone));
            chk($sformatf("i%0d pass", i),      32'(pass_o[i]), 32'(epass));
            chk($sformatf("i%0d wr_en", i),     32'(wr_o[i]),   32'(ewr));
            chk($sformatf("i%0d w_addr", i),    32'(wa_o[i]),   32'(ewa));
            chk($sformatf("i%0d w_data", i),    wd_o[i],        ewd);
            chk($sformatf("i%0d r_addr1", i),   32'(ra1_o[i]),  32'(era1));
            chk($sformatf("i%0d r_addr2", i),   32'(ra2_o[i]),  32'(era2));
            chk($sformatf("i%0d err_count", i), 32'(err_o[i]),  32'(eerr));
            chk($sformatf("i%0d fail_addr", i), 32'(fa_o[i]),   32'(efa));
            chk($sformatf("i%0d fail_data", i), fd_o[i],        efd);
        end
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] snap_wd  [201];
    int          snap_ra1 [201];
    int          snap_err [201];

    // Pulse start on instance i; cycle 0 is the sampling edge. Returns done cycle or -1.
    task automatic run_test(input int i, output int dcyc);
        start[i] = 1'b1;
        @(posedge clk);
        #2 start[i] = 1'b0;
        dcyc = -1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            snap_wd[n] = wd_o[i]; snap_ra1[n] = ra1_o[i]; snap_err[n] = err_o[i];
            if (done_o[i]) begin dcyc = n; break; end
        end
        if (dcyc < 0) chk("done timeout", 32'hFFFF_FFFF, 32'(tot(i)));
        @(posedge clk);
        #2;
    endtask

    initial begin
        int dc, first_done, early_done;
        rst = 3'b111; start = 3'b000;
        repeat (3) @(posedge clk);
        #2 rst = 3'b000;
        @(negedge clk);
        chk("reset busy", 32'(busy_o[0]), 32'd0);
        chk("reset pass", 32'(pass_o[0]), 32'd0);
        chk("reset err",  32'(err_o[0]),  32'd0);
        @(posedge clk); #2;

        // Ideal register file.
        run_test(0, dc);
        chk("ideal done cycle", 32'(dc), 32'd97);
        chk("ideal w_data a9",  snap_wd[10], 32'h5555_555C);
        chk("ideal pass",       32'(pass_o[0]), 32'd1);
        chk("ideal err",        32'(err_o[0]),  32'd0);

        // r9 bit 3 stuck at 0.
        stuck9 = 1'b1;
        run_test(0, dc);
        chk("stuck err",       32'(err_o[0]), 32'd1);
        chk("stuck fail_addr", 32'(fa_o[0]),  32'd9);
        chk("stuck fail_data", fd_o[0],       32'h5555_5554);
        chk("stuck pass",      32'(pass_o[0]), 32'd0);
        stuck9 = 1'b0;

        // r4/r5 read 0 in pass 0: one compare adds two.
        drop45 = 1'b1;
        run_test(0, dc);
        chk("drop45 err before pair",  32'(snap_err[35]), 32'd0);
        chk("drop45 err after pair",   32'(snap_err[36]), 32'd2);
        chk("drop45 fail_addr",        32'(fa_o[0]), 32'd4);
        chk("drop45 fail_data",        fd_o[0],      32'd0);
        chk("drop45 err",              32'(err_o[0]), 32'd2);
        drop45 = 1'b0;

        // Start at 0, ignored start at 20, reset at 40, new start at 50.
        first_done = -1; early_done = 0;
        for (int c = 0; c <= 160; c++) begin
            start[0] = (c == 0 || c == 20 || c == 50);
            rst[0]   = (c == 40);
            @(posedge clk);
            @(negedge clk);
            if (c == 20) chk("ignored start busy", 32'(busy_o[0]), 32'd1);
            if (c == 40) begin
                chk("after reset busy",  32'(busy_o[0]), 32'd0);
                chk("after reset wr_en", 32'(wr_o[0]),   32'd0);
                chk("after reset err",   32'(err_o[0]),  32'd0);
            end
            if (done_o[0]) begin
                if (c + 1 <= 50) early_done++;
                else if (first_done < 0) first_done = c + 1;
            end
        end
        start[0] = 1'b0; rst[0] = 1'b0;
        chk("reset test early done", 32'(early_done), 32'd0);
        chk("restart done cycle",    32'(first_done), 32'd147);
        chk("restart pass",          32'(pass_o[0]),  32'd1);
        @(posedge clk); #2;

        // SKIP_R0 = 0 against a hardwired-zero r0.
        run_test(1, dc);
        chk("noskip err",       32'(err_o[1]), 32'd2);
        chk("noskip fail_addr", 32'(fa_o[1]),  32'd0);
        chk("noskip fail_data", fd_o[1],       32'd0);
        chk("noskip pass",      32'(pass_o[1]), 32'd0);

        // Registered read.
        run_test(2, dc);
        chk("rdlat done cycle",   32'(dc), 32'd129);
        chk("rdlat r_addr1 c33",  32'(snap_ra1[33]), 32'd0);
        chk("rdlat r_addr1 c34",  32'(snap_ra1[34]), 32'd0);
        chk("rdlat r_addr1 c35",  32'(snap_ra1[35]), 32'd2);
        chk("rdlat r_addr1 c36",  32'(snap_ra1[36]), 32'd2);
        chk("rdlat pass",         32'(pass_o[2]), 32'd1);

        // start held high across done launches the next test.
        start[0] = 1'b1;
        dc = -1;
        for (int n = 0; n <= 120; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_o[0] && dc < 0) dc = n + 1;
            if (dc > 0 && n + 1 == dc + 2) begin
                chk("held start busy", 32'(busy_o[0]), 32'd1);
                break;
            end
        end
        start[0] = 1'b0;
        chk("held start first done", 32'(dc), 32'd97);
        dc = -1;
        for (int n = 0; n <= 150; n++) begin
            @(negedge clk);
            if (done_o[0]) begin dc = n; break; end
        end
        if (dc < 0) chk("held start second done", 32'hFFFF_FFFF, 32'd0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/drap_regfile_bist.md
# drap_regfile_bist

Built-in self-test controller for the DRAP_REGFILE 32x32 register file. It owns the register file's write port and both read ports, acting as their initiator. On `start`, it runs two full write/read-back passes with complementary patterns. It then reports pass/fail, a saturating mismatch count and the first failing register and data. It sits beside DRAP_REGFILE in MIPS_Archi and is muxed onto the register file ports while `busy` is high.

## Interface
- `RD_LAT`, 0: register-file read latency in cycles. 0 means combinational read; 1 means registered read.
- `SKIP_R0`, 1: when 1, register 0 is expected to read 32'h0 (hardwired zero); when 0, register 0 is expected to read back the written pattern.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a test; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse at test completion.
- `pass`  out  1  set with `done` when `err_count`==0; held until the next accepted `start`.
- `err_count`  out  6  number of mismatching reads, saturating at 63.
- `fail_addr`  out  5  register address of the first mismatch.
- `fail_data`  out  32  data actually read at the first mismatch.
- `wr_en`  out  1  register file write enable.
- `w_addr`  out  5  register file write address.
- `w_data`  out  32  register file write data.
- `r_addr1`  out  5  read address, port 1 (even registers).
- `r_addr2`  out  5  read address, port 2 (odd registers).
- `r_data1`  in  32  read data, port 1.
- `r_data2`  in  32  read data, port 2.

## Operation
- **Pattern.** For pass p (0/1) and address a, P(p,a) = (p ? 32'hAAAA_AAAA : 32'h5555_5555) ^ {27'd0,a}. The expected value E is P, except that E = 0 for a = 0 when `SKIP_R0` = 1.
- **FSM states:** IDLE, WRITE, READ, RWAIT (only when `RD_LAT` = 1), DONE.
- **IDLE.** When `start` is 1, clear `err_count`, `fail_addr`, `fail_data` and `pass`, set p = 0, and go to WRITE with address 0. `start` is ignored in every other state.
- **WRITE.** `wr_en` = 1, `w_addr` = a, `w_data` = P(p,a), for a = 0..31 (one per cycle). After a = 31, go to READ with k = 0.
- **READ.** `wr_en` = 0; `r_addr1` = 2k, `r_addr2` = 2k+1.
  - With `RD_LAT` = 0: compare `r_data1`/`r_data2` against their E values at the end of the same cycle.
  - With `RD_LAT` = 1: hold the addresses through RWAIT and compare at the end of RWAIT.
- **After k = 15:** if p = 0, set p = 1 and go to WRITE with a = 0; otherwise go to DONE.
- **Error counting.** Add 0, 1 or 2 to `err_count` per compare, saturating at 63.
- **First mismatch.** Captured only when `err_count` was 0 before the compare. If both ports mismatch in the same cycle, port 1 (lower address) wins.
- **DONE.** `done` = 1 for one cycle, `pass` = (`err_count` == 0), `busy` = 0, then go to IDLE.
- **Idle outputs.** When not writing, `w_addr`, `w_data` = 0. When not in READ/RWAIT, `r_addr1`, `r_addr2` = 0.
- **Reset.** While `rst` = 1: state IDLE and all outputs 0. Reset mid-test aborts the test, and `wr_en` is 0 after that edge. Reset has priority over `start`.

## Timing
- All outputs are registered. Reset value of every output is 0, including `pass`.
- Cycle 0 is the edge that samples `start`. `busy` and the first write are visible in cycle 1.
- `RD_LAT` = 0:
  - Pass 0: writes in cycles 1–32, reads in 33–48.
  - Pass 1: writes in 49–80, reads in 81–96.
  - `done` = 1 and `busy` = 0 in cycle 97. Total 97 cycles.
- `RD_LAT` = 1: each read pair takes 2 cycles, so there are 32 read cycles per pass. `done` is in cycle 129.
- `err_count`, `fail_*` update on the edge ending each compare cycle.
- `start` held high across `done` begins a new test in the cycle after DONE.

## Test plan
- **Ideal register file, `RD_LAT` = 0, `SKIP_R0` = 1, r0 hardwired 0.**
  - Stimulus: `start` pulse.
  - Required: `busy` in cycles 1–96; `done` in cycle 97; `pass` = 1; `err_count` = 0.
  - Required: `w_data` for a = 9 in pass 0 is 32'h5555_555C.
- **Bit 3 of register 9 stuck-at-0.**
  - Stimulus: `start` pulse.
  - Required: `err_count` = 1 (pass 1 value 32'hAAAA_AAA3 is unaffected); `fail_addr` = 9; `fail_data` = 32'h5555_5554; `pass` = 0.
- **`SKIP_R0` = 0 with r0 hardwired 0.**
  - Stimulus: `start` pulse.
  - Required: `err_count` = 2; `fail_addr` = 0; `fail_data` = 0; `pass` = 0.
- **Registers 4 and 5 both return 0 in pass 0.**
  - Stimulus: `start` pulse.
  - Required: a single compare adds 2; `fail_addr` = 4 (port 1 priority); `err_count` = 2.
- **`rst` = 1 for one cycle at cycle 40, then `start` pulses at cycles 20 and 50.**
  - Required: the `start` at cycle 20 is ignored (test already running).
  - Required: after the reset edge, `busy` = 0, `wr_en` = 0 and `err_count` = 0.
  - Required: the `start` at cycle 50 runs a full test with `done` 97 cycles later.
- **`RD_LAT` = 1 with a 1-cycle-registered register file model.**
  - Stimulus: `start` pulse.
  - Required: `r_addr1`/`r_addr2` hold for 2 cycles each; `done` in cycle 129; `pass` = 1.
